// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain/unpack path.
// Contents:
//   FIFO_WIDTH_DEFAULT / FIFO_RATIO_DEFAULT - default word width and beats per word
//   occ_t                                   - slot-buffer occupancy count (0..2)
//   ratio_legal()                           - parameter legality: RATIO power of 2, >=2, divides WIDTH
//   beat_bits()                             - width of the beat counter for a given RATIO
package fifo_pkg;

  localparam int FIFO_WIDTH_DEFAULT = 16;
  localparam int FIFO_RATIO_DEFAULT = 2;

  typedef logic [1:0] occ_t;

  function automatic bit ratio_legal(input int width, input int ratio);
    return (ratio >= 2) && ((ratio & (ratio - 1)) == 0) && ((width % ratio) == 0);
  endfunction

  // Clamped to 1 so an illegal RATIO still elaborates far enough to hit the legality error.
  function automatic int beat_bits(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/unpack_slot_buf.sv
// Two-entry word buffer feeding the unpacker's output.
// Slot 0 is the head word being emitted; slot 1 holds the next word.
// Ports:
//   clk, reset_n   - clock, synchronous active-low reset
//   clr            - synchronous clear of both slots (dominates capture)
//   cap_en/data    - write a word into the lowest free slot this edge
//   retire         - head word fully emitted; slot 1 moves up
//   head_valid/data- slot 0 contents
//   occupancy      - number of valid slots (0..2)
module unpack_slot_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             cap_en,
  input  logic [WIDTH-1:0] cap_data,
  input  logic             retire,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output occ_t             occupancy
);

  logic             v0_q, v0_d, v1_q, v1_d;
  logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;

  always_comb begin
    v0_d = v0_q;
    v1_d = v1_q;
    s0_d = s0_q;
    s1_d = s1_q;
    // Retire first so a capture in the same cycle sees the freed head slot.
    if (retire) begin
      v0_d = v1_q;
      s0_d = s1_q;
      v1_d = 1'b0;
    end
    // The pop rule guarantees a free slot exists whenever a capture arrives.
    if (cap_en) begin
      if (!v0_d) begin
        v0_d = 1'b1;
        s0_d = cap_data;
      end else begin
        v1_d = 1'b1;
        s1_d = cap_data;
      end
    end
    if (clr) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      v0_q <= v0_d;
      v1_q <= v1_d;
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

  assign head_valid = v0_q;
  assign head_data  = s0_q;
  assign occupancy  = {v0_q & v1_q, v0_q ^ v1_q};

endmodule

// File: rtl/fifo_unpacker.sv
// Drain stage for the push/pop FIFO: pops WIDTH-bit words and re-emits each
// as RATIO beats of WIDTH/RATIO bits on a valid/ready stream, LSB slice first.
// A two-word buffer plus one in-flight pop covers the FIFO's read latency so
// an unstalled consumer sees one beat per cycle with no gaps between words.
// Ports:
//   clk, reset_n   - clock, synchronous active-low reset
//   flush          - synchronous clear of buffered and in-flight words
//   fifo_empty     - FIFO empty flag
//   fifo_pop       - pop request (combinational)
//   fifo_data      - FIFO read data, valid the cycle after an accepted pop
//   out_valid/ready/data/last - beat stream; out_last marks slice RATIO-1
module fifo_unpacker
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int RATIO = FIFO_RATIO_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   fifo_empty,
  output logic                   fifo_pop,
  input  logic [WIDTH-1:0]       fifo_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH/RATIO-1:0] out_data,
  output logic                   out_last
);

  localparam int OUT_W  = WIDTH / RATIO;
  localparam int BEAT_W = beat_bits(RATIO);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

  if (!ratio_legal(WIDTH, RATIO)) begin : g_param_check
    $error("fifo_unpacker: RATIO must be a power of 2, >= 2, and divide WIDTH");
  end

  logic              pend_q, pend_d;
  logic              discard_q, discard_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic              head_valid;
  logic [WIDTH-1:0]  head_data;
  occ_t              occupancy;
  logic              capture, xfer, last_xfer;
  logic [OUT_W-1:0]  slices [RATIO];

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    assign slices[gi] = head_data[gi*OUT_W +: OUT_W];
  end

  assign out_valid = head_valid;
  assign out_data  = head_valid ? slices[beat_q] : '0;
  assign out_last  = head_valid & (beat_q == LAST_BEAT);

  assign xfer      = out_valid & out_ready;
  assign last_xfer = xfer & (beat_q == LAST_BEAT);

  // A word popped just before a flush/reset is never captured.
  assign capture   = pend_q & ~discard_q;

  // Slots plus the in-flight pop never exceed the two-word buffer.
  assign fifo_pop  = reset_n & ~flush & ~fifo_empty & ((occupancy + {1'b0, pend_q}) < 2'd2);

  always_comb begin
    pend_d    = fifo_pop;
    discard_d = flush;
    beat_d    = beat_q;
    if (flush) begin
      pend_d = 1'b0;
      beat_d = '0;
    end else if (xfer) begin
      beat_d = last_xfer ? '0 : beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q    <= 1'b0;
      discard_q <= 1'b1;
      beat_q    <= '0;
    end else begin
      pend_q    <= pend_d;
      discard_q <= discard_d;
      beat_q    <= beat_d;
    end
  end

  unpack_slot_buf #(
    .WIDTH(WIDTH)
  ) u_slot_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (flush),
    .cap_en    (capture),
    .cap_data  (fifo_data),
    .retire    (last_xfer),
    .head_valid(head_valid),
    .head_data (head_data),
    .occupancy (occupancy)
  );

endmodule
